// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: segment patterns (active-low
// {a..g}), digit count, FSM encoding and anode helper functions.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
    localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
    localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
    localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
    localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
    localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0000100;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b1100000;
    localparam logic [6:0] SEG_HEX_C = 7'b0110001;
    localparam logic [6:0] SEG_HEX_D = 7'b1000010;
    localparam logic [6:0] SEG_HEX_E = 7'b0110000;
    localparam logic [6:0] SEG_HEX_F = 7'b0111000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_HOLD    = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    function automatic logic is_one_cold(input logic [NUM_DIGITS-1:0] a);
        return ($countones(~a) == 1);
    endfunction

    function automatic logic [2:0] cold_index(input logic [NUM_DIGITS-1:0] a);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!a[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from an active-low segment pattern back to a hex nibble,
// flagging the all-off pattern as blank and anything unknown as bad.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       bad
);

    // Pattern lookup; unknown and blank patterns both read back as nibble 0.
    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        bad    = 1'b0;
        case (seg)
            SEG_HEX_0: nibble = 4'h0;
            SEG_HEX_1: nibble = 4'h1;
            SEG_HEX_2: nibble = 4'h2;
            SEG_HEX_3: nibble = 4'h3;
            SEG_HEX_4: nibble = 4'h4;
            SEG_HEX_5: nibble = 4'h5;
            SEG_HEX_6: nibble = 4'h6;
            SEG_HEX_7: nibble = 4'h7;
            SEG_HEX_8: nibble = 4'h8;
            SEG_HEX_9: nibble = 4'h9;
            SEG_HEX_A: nibble = 4'hA;
            SEG_HEX_B: nibble = 4'hB;
            SEG_HEX_C: nibble = 4'hC;
            SEG_HEX_D: nibble = 4'hD;
            SEG_HEX_E: nibble = 4'hE;
            SEG_HEX_F: nibble = 4'hF;
            SEG_BLANK: blank  = 1'b1;
            default:   bad    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Observes a multiplexed 8-digit 7-segment scan and rebuilds the displayed
// hex frame, flagging blank/undecodable digits and illegal anode values.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  anode,
    input  logic [6:0]  cathode,
    output logic [31:0] digits,
    output logic [7:0]  blank,
    output logic [7:0]  bad,
    output logic        frame_valid,
    output logic        scan_err
);

    localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
    localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);

    state_t      state_q, state_d;
    logic [7:0]  anode_q, anode_p_q, hold_anode_q, hold_anode_d;
    logic [6:0]  cath_q, cap_cath_q, cap_cath_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] shadow_dig_q, shadow_dig_d, digits_q, digits_d;
    logic [7:0]  shadow_blank_q, shadow_blank_d, shadow_bad_q, shadow_bad_d;
    logic [7:0]  seen_q, seen_d, blank_q, blank_d, bad_q, bad_d;
    logic        frame_valid_q, frame_valid_d, scan_err_q, scan_err_d;
    logic [7:0]  seen_new_s;
    logic [2:0]  cap_idx_s;
    logic [3:0]  dec_nibble_s;
    logic        dec_blank_s, dec_bad_s;
    logic        anode_chg_s;

    seg7_pattern_decode u_decode (
        .seg    (cap_cath_q),
        .nibble (dec_nibble_s),
        .blank  (dec_blank_s),
        .bad    (dec_bad_s)
    );

    assign anode_chg_s = (anode_q != anode_p_q);
    assign cap_idx_s   = cold_index(hold_anode_q);

    // Next-state, stability counter, shadow bank and output bank.
    always_comb begin
        state_d        = state_q;
        hold_anode_d   = hold_anode_q;
        cap_cath_d     = cap_cath_q;
        shadow_dig_d   = shadow_dig_q;
        shadow_blank_d = shadow_blank_q;
        shadow_bad_d   = shadow_bad_q;
        seen_d         = seen_q;
        digits_d       = digits_q;
        blank_d        = blank_q;
        bad_d          = bad_q;
        frame_valid_d  = 1'b0;
        scan_err_d     = 1'b0;
        seen_new_s     = seen_q | (8'd1 << cap_idx_s);

        if (anode_chg_s) begin
            cnt_d = 8'd0;
        end else if (cnt_q == SETTLE_C) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                // A value that changes on this very cycle has not yet settled.
                if (cnt_q == SETTLE_M1 && !anode_chg_s) begin
                    hold_anode_d = anode_q;
                    state_d      = is_one_cold(anode_q) ? ST_ARM : ST_ERR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                cap_cath_d = cath_q;
                state_d    = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                shadow_dig_d[cap_idx_s*4 +: 4] = dec_nibble_s;
                shadow_blank_d[cap_idx_s]      = dec_blank_s;
                shadow_bad_d[cap_idx_s]        = dec_bad_s;
                if (seen_new_s == 8'hFF) begin
                    digits_d      = shadow_dig_d;
                    blank_d       = shadow_blank_d;
                    bad_d         = shadow_bad_d;
                    frame_valid_d = 1'b1;
                    seen_d        = 8'h00;
                end else begin
                    seen_d = seen_new_s;
                end
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Compare against the captured value so a change seen during ARM/CAPTURE is not lost.
                if (anode_q != hold_anode_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_ERR: begin
                scan_err_d = 1'b1;
                state_d    = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            anode_q        <= 8'hFF;
            anode_p_q      <= 8'hFF;
            cath_q         <= 7'h7F;
            hold_anode_q   <= 8'hFF;
            cap_cath_q     <= 7'h7F;
            cnt_q          <= 8'd0;
            shadow_dig_q   <= 32'd0;
            shadow_blank_q <= 8'd0;
            shadow_bad_q   <= 8'd0;
            seen_q         <= 8'd0;
            digits_q       <= 32'd0;
            blank_q        <= 8'd0;
            bad_q          <= 8'd0;
            frame_valid_q  <= 1'b0;
            scan_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            anode_q        <= anode;
            anode_p_q      <= anode_q;
            cath_q         <= cathode;
            hold_anode_q   <= hold_anode_d;
            cap_cath_q     <= cap_cath_d;
            cnt_q          <= cnt_d;
            shadow_dig_q   <= shadow_dig_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_bad_q   <= shadow_bad_d;
            seen_q         <= seen_d;
            digits_q       <= digits_d;
            blank_q        <= blank_d;
            bad_q          <= bad_d;
            frame_valid_q  <= frame_valid_d;
            scan_err_q     <= scan_err_d;
        end
    end

    assign digits      = digits_q;
    assign blank       = blank_q;
    assign bad         = bad_q;
    assign frame_valid = frame_valid_q;
    assign scan_err    = scan_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: expected frames are queued as each frame
// is driven and checked when frame_valid pulses.
module tb_seg7_scan_decoder;

    typedef struct packed {
        logic [31:0] dig;
        logic [7:0]  blk;
        logic [7:0]  bd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic [31:0] digits;
    logic [7:0]  blank;
    logic [7:0]  bad_o;
    logic        frame_valid;
    logic        scan_err;

    exp_t exp_q[$];
    int   total = 0;
    int   bad_cnt = 0;
    int   frames = 0;
    int   err_pulses = 0;

    seg7_scan_decoder #(.SETTLE(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .anode       (anode),
        .cathode     (cathode),
        .digits      (digits),
        .blank       (blank),
        .bad         (bad_o),
        .frame_valid (frame_valid),
        .scan_err    (scan_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic show(input int idx, input logic [6:0] pat, input int cyc);
        anode   = ~(8'b1 << idx);
        cathode = pat;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_digits"}, digits, 32'd0);
        chk({tag, "_blank"}, {24'd0, blank}, 32'd0);
        chk({tag, "_bad"}, {24'd0, bad_o}, 32'd0);
        chk({tag, "_fv"}, {31'd0, frame_valid}, 32'd0);
        chk({tag, "_err"}, {31'd0, scan_err}, 32'd0);
    endtask

    // Output monitor: counts pulses and checks each completed frame against the queue.
    always @(negedge clk) begin
        if (scan_err === 1'b1) err_pulses++;
        if (frame_valid === 1'b1) begin
            exp_t e;
            frames++;
            chk("fv_expected", {31'd0, (exp_q.size() > 0)}, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("frame_digits", digits, e.dig);
                chk("frame_blank", {24'd0, blank}, {24'd0, e.blk});
                chk("frame_bad", {24'd0, bad_o}, {24'd0, e.bd});
            end
        end
    end

    initial begin
        exp_t e;
        reset_n = 1'b0;
        anode   = 8'hFF;
        cathode = 7'h7F;

        // Reset with random inputs.
        for (int i = 0; i < 3; i++) begin
            anode   = 8'($urandom);
            cathode = 7'($urandom);
            @(negedge clk);
            chk_zero("reset");
        end
        reset_n = 1'b1;

        // Full frame 0..7.
        e = '{dig: 32'h76543210, blk: 8'h00, bd: 8'h00};
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) show(i, enc(4'(i)), 10);
        chk("frames_after_a", frames, 32'd1);

        // Glitch on digit 1 between digits 0 and 2; digit 1 shown properly last.
        e = '{dig: 32'hFEDCBA98, blk: 8'h00, bd: 8'h00};
        exp_q.push_back(e);
        show(0, enc(4'h8), 10);
        show(1, enc(4'h3), 2);
        for (int i = 2; i < 8; i++) show(i, enc(4'(i + 8)), 10);
        chk("glitch_no_frame", frames, 32'd1);
        chk("glitch_no_err", err_pulses, 32'd0);
        show(1, enc(4'h9), 10);
        chk("frames_after_b", frames, 32'd2);

        // Illegal anode mid-frame plus blank digit 3 and bad digit 5.
        e = '{dig: 32'hEC060421, blk: 8'h08, bd: 8'h20};
        exp_q.push_back(e);
        show(0, enc(4'h1), 10);
        show(1, enc(4'h2), 10);
        show(2, enc(4'h4), 10);
        anode = 8'hF3;
        repeat (8) @(negedge clk);
        chk("illegal_err_once", err_pulses, 32'd1);
        show(3, 7'b1111111, 10);
        show(4, enc(4'h6), 10);
        show(5, 7'b1010101, 10);
        show(6, enc(4'hC), 10);
        show(7, enc(4'hE), 10);
        chk("frames_after_c", frames, 32'd3);

        // Reset after five digits, then a frame of F's.
        for (int i = 0; i < 5; i++) show(i, enc(4'h5), 10);
        reset_n = 1'b0;
        @(negedge clk);
        chk_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        e = '{dig: 32'hFFFFFFFF, blk: 8'h00, bd: 8'h00};
        exp_q.push_back(e);
        for (int i = 0; i < 7; i++) show(i, enc(4'hF), 10);
        chk("partial_no_frame", frames, 32'd3);
        show(7, enc(4'hF), 10);
        show(0, enc(4'hF), 5);

        chk("frames_total", frames, 32'd4);
        chk("err_total", err_pulses, 32'd1);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad_cnt);
        $finish;
    end

endmodule
